sig_edge_filter: RTL

SIG_EDGE_FILTER -- requirements
Module: sig_edge_filter

---
 rtl/sig_edge_filter_pkg.sv | 20 ++
 rtl/sig_edge_filter_sync.sv | 26 ++
 rtl/sig_edge_filter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sig_edge_filter_pkg.sv
// Shared constants and types for the sig_edge_filter block:
// FSM state encoding, qualification counter width and parameter defaults.
package sig_edge_filter_pkg;

  localparam int CNT_W = 8;

  localparam int   DEF_STABLE_CYCLES = 16;
  localparam logic DEF_RESET_VALUE   = 1'b0;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_QUALIFY = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Count value at which a still-differing sample commits.
  function automatic cnt_t lastCnt(input int stable);
    return cnt_t'(stable - 1);
  endfunction

endpackage

// File: rtl/sig_edge_filter_sync.sv
// Two-flop synchronizer bringing an asynchronous level into i_OClk.
// Both stages reset asynchronously to RESET_VALUE.
module sig_sync2
  import sig_edge_filter_pkg::*;
#(
  parameter logic RESET_VALUE = DEF_RESET_VALUE
) (
  input  logic i_OClk,
  input  logic i_aOReset_N,
  input  logic i_iSig,
  output logic o_oSync
);

  logic meta;

  always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
    if (!i_aOReset_N) begin
      meta    <= RESET_VALUE;
      o_oSync <= RESET_VALUE;
    end else begin
      meta    <= i_iSig;
      o_oSync <= meta;
    end
  end

endmodule

// File: rtl/sig_edge_filter.sv
// Synchronizing edge filter with optional debounce qualification;
// EDGE_FILTER_DEBOUNCE_EN compiles in the IDLE/QUALIFY FSM and counter.
module sig_edge_filter
  import sig_edge_filter_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VALUE   = DEF_RESET_VALUE
) (
  input  logic i_OClk,
  input  logic i_aOReset_N,
  input  logic i_iSig,
  input  logic i_oClear,
  output logic o_oLevel,
  output logic o_oRise,
  output logic o_oFall,
  output logic o_oBusy
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : gBadCfg
    $error("sig_edge_filter: STABLE_CYCLES must be 1..255");
  end

  logic sync;
  logic level;
  logic rise;
  logic fall;

  sig_sync2 #(
    .RESET_VALUE (RESET_VALUE)
  ) uSync (
    .i_OClk      (i_OClk),
    .i_aOReset_N (i_aOReset_N),
    .i_iSig      (i_iSig),
    .o_oSync     (sync)
  );

`ifdef EDGE_FILTER_DEBOUNCE_EN

  localparam cnt_t LastCnt = lastCnt(STABLE_CYCLES);

  logic [0:0] state;
  logic [0:0] stateNxt;
  cnt_t       cnt;
  cnt_t       cntNxt;
  logic       levelNxt;
  logic       riseNxt;
  logic       fallNxt;
  logic       commit;
  logic       run;
  logic       diff;
  logic       isQual;
  logic       atLast;

  assign run    = !i_oClear;
  assign diff   = sync != level;
  assign isQual = state == ST_QUALIFY;
  assign atLast = cnt == LastCnt;

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    levelNxt = level;
    riseNxt  = 1'b0;
    fallNxt  = 1'b0;
    commit   = 1'b0;
    unique case (1'b1)
      i_oClear: begin
        levelNxt = RESET_VALUE;
        stateNxt = ST_IDLE;
        cntNxt   = '0;
      end
      run && !isQual && diff: begin
        if (STABLE_CYCLES == 1) begin
          commit = 1'b1;
        end else begin
          stateNxt = ST_QUALIFY;
          cntNxt   = cnt_t'(1);
        end
      end
      // Sample fell back to the committed level: glitch rejected.
      run && isQual && !diff: begin
        stateNxt = ST_IDLE;
        cntNxt   = '0;
      end
      run && isQual && diff && atLast: begin
        commit = 1'b1;
      end
      run && isQual && diff && !atLast: begin
        cntNxt = cnt + cnt_t'(1);
      end
      default: ;
    endcase
    if (commit) begin
      levelNxt = sync;
      riseNxt  = sync;
      fallNxt  = !sync;
      stateNxt = ST_IDLE;
      cntNxt   = '0;
    end
  end

  always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
    if (!i_aOReset_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
      level <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      level <= levelNxt;
      rise  <= riseNxt;
      fall  <= fallNxt;
    end
  end

  assign o_oBusy = isQual;

`else

  always_ff @(posedge i_OClk or negedge i_aOReset_N) begin
    if (!i_aOReset_N) begin
      level <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= i_oClear ? RESET_VALUE : sync;
      rise  <= !i_oClear && sync && !level;
      fall  <= !i_oClear && !sync && level;
    end
  end

  assign o_oBusy = 1'b0;

`endif

  assign o_oLevel = level;
  assign o_oRise  = rise;
  assign o_oFall  = fall;

endmodule
